rx_event_arbiter: RTL and testbench

- Parametrised successor to the backend's fixed 4-module receive mux.
- Buffers data words (singles/timetags) from NMODULES frontend receivers in per-channel FIFOs.
- Arbitrates them onto one registered valid/ready stream toward the Ethernet FIFO, tagging each word with its source module.
- Keeps per-module singles/timetag/drop counters behind a select/clear readout port for the microblaze GPIO.

---
 rtl/rx_event_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_rx_event_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rx_event_arbiter
//  Purpose  : Buffers event words from NMODULES frontend receivers in
//             per-channel FIFOs and arbitrates them (fixed priority or
//             round-robin) onto one registered valid/ready stream tagged with
//             the source channel. Keeps per-channel singles/timetag/drop
//             counters behind a select/clear readout port.
//  Options  : RX_EVENT_ARBITER_FLUSH_EN adds a synchronous 'flush' input that
//             empties all FIFOs and the output register.
//  Revision : 1.0  initial release
// ============================================================================
module rx_event_arbiter #(
   parameter int NMODULES        = 4,
   parameter int LENGTH          = 128,
   parameter int DEPTH           = 16,
   parameter int ARB_MODE        = 1,
   parameter int SGL_FLAG_OFFSET = 122,
   parameter int CNT_WIDTH       = 48
) (
   input  logic                          clk,
   input  logic                          rst,
`ifdef RX_EVENT_ARBITER_FLUSH_EN
   input  logic                          flush,
`endif
   input  logic [NMODULES-1:0]           in_valid,
   output logic [NMODULES-1:0]           in_ready,
   input  logic [NMODULES*LENGTH-1:0]    in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LENGTH-1:0]             out_data,
   output logic [$clog2(NMODULES)-1:0]   out_src,
   input  logic [$clog2(NMODULES)-1:0]   cnt_sel_module,
   input  logic [1:0]                    cnt_sel_chan,
   input  logic                          cnt_clear,
   output logic [CNT_WIDTH-1:0]          cnt_value
);

   localparam int c_idx_w = $clog2(NMODULES);
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_nchan = 3;   // singles, timetags, drops

   logic flush_w;
`ifdef RX_EVENT_ARBITER_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // FIFO storage and bookkeeping
   logic [LENGTH-1:0]    mem_q    [NMODULES][DEPTH];
   logic [c_ptr_w-1:0]   wr_ptr_q [NMODULES];
   logic [c_ptr_w-1:0]   wr_ptr_d [NMODULES];
   logic [c_ptr_w-1:0]   rd_ptr_q [NMODULES];
   logic [c_ptr_w-1:0]   rd_ptr_d [NMODULES];
   logic [c_ptr_w:0]     count_q  [NMODULES];
   logic [c_ptr_w:0]     count_d  [NMODULES];

   logic [NMODULES-1:0]  full;
   logic [NMODULES-1:0]  nonempty;
   logic [NMODULES-1:0]  push;
   logic [NMODULES-1:0]  drop;
   logic [NMODULES-1:0]  pop;
   logic [NMODULES-1:0]  sgl;
   logic                 load;
   logic                 any_req;
   logic [c_idx_w-1:0]   grant;

   logic [c_idx_w-1:0]   rr_ptr_q, rr_ptr_d;
   logic                 out_valid_q, out_valid_d;
   logic [LENGTH-1:0]    out_data_q, out_data_d;
   logic [c_idx_w-1:0]   out_src_q, out_src_d;

   logic [CNT_WIDTH-1:0] cnt_q [NMODULES][c_nchan];
   logic [CNT_WIDTH-1:0] cnt_d [NMODULES][c_nchan];

   // Per-channel status; full is sampled before the edge, so a same-cycle pop never rescues a word
   always_comb begin
      for (int i = 0; i < NMODULES; i++) begin
         full[i]     = (count_q[i] == (c_ptr_w+1)'(DEPTH));
         nonempty[i] = (count_q[i] != '0);
         push[i]     = in_valid[i] & ~full[i] & ~flush_w;
         drop[i]     = in_valid[i] &  full[i] & ~flush_w;
         sgl[i]      = in_data[i*LENGTH + SGL_FLAG_OFFSET];
      end
   end

   assign in_ready = ~full;
   assign load     = ~out_valid_q | out_ready;

   // Grant selection: lowest index, or first non-empty channel at/after the round-robin pointer
   always_comb begin
      int                 idx;
      logic [c_idx_w-1:0] cand;
      idx     = 0;
      cand    = '0;
      grant   = '0;
      any_req = |nonempty;
      for (int off = NMODULES-1; off >= 0; off--) begin
         if (ARB_MODE == 0) begin
            idx = off;
         end else begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NMODULES) idx = idx - NMODULES;
         end
         cand = c_idx_w'(idx);
         if (nonempty[cand]) grant = cand;
      end
   end

   // FIFO pointer/count updates and pop strobes
   always_comb begin
      for (int i = 0; i < NMODULES; i++) begin
         pop[i]      = load & any_req & ~flush_w & (grant == c_idx_w'(i));
         wr_ptr_d[i] = wr_ptr_q[i] + {{(c_ptr_w-1){1'b0}}, push[i]};
         rd_ptr_d[i] = rd_ptr_q[i] + {{(c_ptr_w-1){1'b0}}, pop[i]};
         count_d[i]  = count_q[i] + {{c_ptr_w{1'b0}}, push[i]} - {{c_ptr_w{1'b0}}, pop[i]};
         if (flush_w) begin
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
            count_d[i]  = '0;
         end
      end
   end

   // Output register: reload whenever empty or being accepted, hold while stalled
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (flush_w) begin
         out_valid_d = 1'b0;
      end else if (load) begin
         out_valid_d = any_req;
         if (any_req) begin
            out_data_d = mem_q[grant][rd_ptr_q[grant]];
            out_src_d  = grant;
            if (ARB_MODE != 0) begin
               rr_ptr_d = (grant == c_idx_w'(NMODULES-1)) ? '0 : grant + 1'b1;
            end
         end
      end
   end

   // Event counters: accepted words split by the singles flag, rejected words count as drops; clear wins
   always_comb begin
      logic inc;
      inc = 1'b0;
      for (int i = 0; i < NMODULES; i++) begin
         for (int j = 0; j < c_nchan; j++) begin
            case (j)
               0:       inc = push[i] &  sgl[i];
               1:       inc = push[i] & ~sgl[i];
               default: inc = drop[i];
            endcase
            cnt_d[i][j] = cnt_q[i][j] + {{(CNT_WIDTH-1){1'b0}}, inc};
            if (cnt_clear && (int'(cnt_sel_module) == i) && (int'(cnt_sel_chan) == j)) begin
               cnt_d[i][j] = '0;
            end
         end
      end
   end

   // Counter readout mux; unselected or out-of-range selections read zero
   always_comb begin
      cnt_value = '0;
      for (int i = 0; i < NMODULES; i++) begin
         for (int j = 0; j < c_nchan; j++) begin
            if ((int'(cnt_sel_module) == i) && (int'(cnt_sel_chan) == j)) cnt_value = cnt_q[i][j];
         end
      end
   end

   // FIFO data storage; no reset needed since contents are only read when the count says valid
   always_ff @(posedge clk) begin
      for (int i = 0; i < NMODULES; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*LENGTH +: LENGTH];
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NMODULES; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
            for (int j = 0; j < c_nchan; j++) cnt_q[i][j] <= '0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_event_arbiter
//  Purpose  : Self-checking bench for rx_event_arbiter. A round-robin and a
//             fixed-priority instance share stimulus; a scoreboard queue
//             holds expected (source, word) pairs checked at each handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rx_event_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   in_valid = '0;
   logic [511:0] in_data = '0;
   logic         out_ready = 1'b0;
   logic [1:0]   cnt_sel_module = '0;
   logic [1:0]   cnt_sel_chan = '0;
   logic         cnt_clear = 1'b0;
`ifdef RX_EVENT_ARBITER_FLUSH_EN
   logic         flush = 1'b0;
`endif

   logic [3:0]   in_ready_rr, in_ready_fp;
   logic         out_valid_rr, out_valid_fp;
   logic [127:0] out_data_rr, out_data_fp;
   logic [1:0]   out_src_rr, out_src_fp;
   logic [47:0]  cnt_value_rr, cnt_value_fp;

   always #5 clk = ~clk;

   rx_event_arbiter #(.ARB_MODE(1)) dut_rr (
      .clk(clk), .rst(rst),
`ifdef RX_EVENT_ARBITER_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(in_ready_rr), .in_data(in_data),
      .out_valid(out_valid_rr), .out_ready(out_ready), .out_data(out_data_rr), .out_src(out_src_rr),
      .cnt_sel_module(cnt_sel_module), .cnt_sel_chan(cnt_sel_chan), .cnt_clear(cnt_clear),
      .cnt_value(cnt_value_rr)
   );

   rx_event_arbiter #(.ARB_MODE(0)) dut_fp (
      .clk(clk), .rst(rst),
`ifdef RX_EVENT_ARBITER_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(in_ready_fp), .in_data(in_data),
      .out_valid(out_valid_fp), .out_ready(out_ready), .out_data(out_data_fp), .out_src(out_src_fp),
      .cnt_sel_module(cnt_sel_module), .cnt_sel_chan(cnt_sel_chan), .cnt_clear(cnt_clear),
      .cnt_value(cnt_value_fp)
   );

   typedef struct packed {
      logic [1:0]   src;
      logic [127:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic mon_en = 1'b0;
   logic mon_sel_rr = 1'b1;

   task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] make_word(input int ch, input int n, input logic s);
      logic [127:0] w;
      w          = '0;
      w[63:32]   = 32'(ch);
      w[31:0]    = 32'(n);
      w[122]     = s;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] mask, input int n, input logic s);
      for (int i = 0; i < 4; i++) in_data[i*128 +: 128] = make_word(i, n, s);
      in_valid = mask;
      tick();
      in_valid = '0;
   endtask

   task automatic expect_word(input int ch, input int n, input logic s);
      exp_t e;
      e.src  = 2'(ch);
      e.data = make_word(ch, n, s);
      exp_q.push_back(e);
   endtask

   task automatic read_cnt(input int m, input int c, input int exp, input string tag);
      cnt_sel_module = 2'(m);
      cnt_sel_chan   = 2'(c);
      #1;
      check_value(tag, 128'(cnt_value_rr), 128'(exp));
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
      check_value({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
      repeat (2) tick();
   endtask

   task automatic do_reset();
      in_valid  = '0;
      cnt_clear = 1'b0;
`ifdef RX_EVENT_ARBITER_FLUSH_EN
      flush     = 1'b0;
`endif
      mon_en    = 1'b0;
      exp_q.delete();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   // Scoreboard monitor: a handshake completes at the next rising edge
   always @(negedge clk) begin : p_mon
      exp_t e;
      if (mon_en && !rst && out_ready && (mon_sel_rr ? out_valid_rr : out_valid_fp)) begin
         if (exp_q.size() == 0) begin
            check_value("sb_unexpected", 128'd1, 128'd0);
         end else begin
            e = exp_q.pop_front();
            check_value("sb_src",  128'(mon_sel_rr ? out_src_rr : out_src_fp), 128'(e.src));
            check_value("sb_data", mon_sel_rr ? out_data_rr : out_data_fp, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state, then reset with words pending in FIFOs 0 and 2
      do_reset();
      check_value("rst_in_ready",  128'(in_ready_rr), 128'hF);
      check_value("rst_out_valid", 128'(out_valid_rr), 128'd0);
      check_value("rst_out_data",  out_data_rr, 128'd0);
      check_value("rst_out_src",   128'(out_src_rr), 128'd0);
      out_ready = 1'b0;
      send(4'b0101, 100, 1'b0);
      send(4'b0101, 101, 1'b0);
      tick();
      check_value("pre_rst_valid", 128'(out_valid_rr), 128'd1);
      check_value("pre_rst_ready", 128'(in_ready_rr), 128'hF);
      rst = 1'b1;
      #1;
      check_value("async_rst_valid", 128'(out_valid_rr), 128'd0);
      tick();
      rst = 1'b0;
      tick();
      check_value("post_rst_valid", 128'(out_valid_rr), 128'd0);
      check_value("post_rst_ready", 128'(in_ready_rr), 128'hF);
      for (int m = 0; m < 4; m++)
         for (int c = 0; c < 3; c++) read_cnt(m, c, 0, "post_rst_cnt");

      // Round-robin: one word per channel, then two more on channel 1
      do_reset();
      mon_sel_rr = 1'b1;
      mon_en     = 1'b1;
      out_ready  = 1'b1;
      for (int ch = 0; ch < 4; ch++) expect_word(ch, 0, 1'b0);
      send(4'hF, 0, 1'b0);
      check_value("rr_lat_early", 128'(out_valid_rr), 128'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check_value("rr_valid", 128'(out_valid_rr), 128'd1);
         check_value("rr_src",   128'(out_src_rr), 128'(k));
      end
      expect_word(1, 1, 1'b0);
      expect_word(1, 2, 1'b0);
      send(4'b0010, 1, 1'b0);
      send(4'b0010, 2, 1'b0);
      wait_drain("rr");

      // Fixed priority: channel 0 drains completely before channel 3
      do_reset();
      mon_sel_rr = 1'b0;
      mon_en     = 1'b1;
      out_ready  = 1'b1;
      for (int n = 0; n < 4; n++) expect_word(0, n, 1'b0);
      for (int n = 0; n < 4; n++) expect_word(3, n, 1'b0);
      for (int n = 0; n < 4; n++) send(4'b1001, n, 1'b0);
      wait_drain("fp");

      // Backpressure: word 0 moves into the output register, the FIFO then
      // absorbs words 1..16, so only the 18th word is dropped
      do_reset();
      mon_sel_rr = 1'b1;
      mon_en     = 1'b1;
      out_ready  = 1'b0;
      for (int n = 0; n < 18; n++) begin
         send(4'b0100, n, 1'b0);
         if (n >= 1) check_value("bp_hold", out_data_rr, make_word(2, 0, 1'b0));
      end
      check_value("bp_in_ready2", 128'(in_ready_rr[2]), 128'd0);
      check_value("bp_src_hold",  128'(out_src_rr), 128'd2);
      read_cnt(2, 2, 1,  "bp_drops2");
      read_cnt(2, 1, 17, "bp_timetags2");
      for (int n = 0; n < 17; n++) expect_word(2, n, 1'b0);
      out_ready = 1'b1;
      wait_drain("bp");

      // Classification counters and clear-over-increment
      do_reset();
      mon_sel_rr = 1'b1;
      mon_en     = 1'b1;
      out_ready  = 1'b1;
      for (int n = 0; n < 5; n++) begin
         expect_word(1, n, 1'b1);
         send(4'b0010, n, 1'b1);
      end
      for (int n = 5; n < 8; n++) begin
         expect_word(1, n, 1'b0);
         send(4'b0010, n, 1'b0);
      end
      wait_drain("cls");
      read_cnt(1, 0, 5, "singles1");
      read_cnt(1, 1, 3, "timetags1");
      read_cnt(1, 2, 0, "drops1");
      read_cnt(1, 3, 0, "chan3_zero");
      cnt_sel_module = 2'd1;
      cnt_sel_chan   = 2'd0;
      cnt_clear      = 1'b1;
      expect_word(1, 8, 1'b1);
      send(4'b0010, 8, 1'b1);
      cnt_clear = 1'b0;
      read_cnt(1, 0, 0, "clr_over_inc");
      read_cnt(1, 1, 3, "clr_keeps_tt");
      wait_drain("clr");

`ifdef RX_EVENT_ARBITER_FLUSH_EN
      // Flush with ten words queued; same-cycle input on channel 2 is discarded
      do_reset();
      out_ready = 1'b0;
      for (int n = 0; n < 5; n++) send(4'b0011, n, 1'b0);
      tick();
      check_value("fl_pre_valid", 128'(out_valid_rr), 128'd1);
      in_data[2*128 +: 128] = make_word(2, 50, 1'b0);
      in_valid = 4'b0100;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = '0;
      check_value("fl_valid", 128'(out_valid_rr), 128'd0);
      check_value("fl_ready", 128'(in_ready_rr), 128'hF);
      read_cnt(0, 1, 5, "fl_tt0");
      read_cnt(1, 1, 5, "fl_tt1");
      read_cnt(2, 1, 0, "fl_tt2");
      read_cnt(2, 2, 0, "fl_drops2");
      out_ready = 1'b1;
      repeat (3) tick();
      check_value("fl_stay_empty", 128'(out_valid_rr), 128'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
